multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: instruction-class FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
// that sequences the datapath strobes. A bounded wait counter guards both memory
// handshakes, and sticky illegal/timeout flags park the FSM in TRAP until reset.
// Optional feature macro: PERF_CNT_EN adds the cycle_cnt/instret_cnt counters.
// MEM_TIMEOUT must be at least 1.
module multicycle_control_unit #(
  parameter int ILEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ILEN-1:0] instruction,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            branch_taken,
  output logic            imem_req,
  output logic            ir_write,
  output logic            pc_write,
  output logic            pc_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            alu_src,
  output logic            reg_write,
  output logic [3:0]      alu_ctrl,
  output logic            illegal,
  output logic            timeout,
  output logic [2:0]      state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_CMP = 4'b1000;

  typedef struct packed {
    logic       legal;
    logic       is_branch;
    logic       is_load;
    logic       is_store;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic [3:0] alu_ctrl;
  } ctl_t;

  // Maps {funct3, opcode} (plus bit 30 for R-type SUB/SRA) to the control bundle.
  // Anything not listed comes back all-zero, i.e. legal=0.
  function automatic ctl_t decode(input logic [6:0] op, input logic [2:0] f3,
                                  input logic b30);
    ctl_t c;
    c = '0;
    case (op)
      7'b0110011: begin
        c.reg_write = 1'b1;
        c.legal     = 1'b1;
        case (f3)
          3'b000:  c.alu_ctrl = b30 ? ALU_SUB : ALU_ADD;
          3'b001:  c.alu_ctrl = ALU_SLL;
          3'b100:  c.alu_ctrl = ALU_XOR;
          3'b101:  c.alu_ctrl = b30 ? ALU_SRA : ALU_SRL;
          3'b110:  c.alu_ctrl = ALU_OR;
          3'b111:  c.alu_ctrl = ALU_AND;
          default: c = '0;
        endcase
      end
      7'b0010011: begin
        // Bit 30 belongs to the immediate here, so ADDI never becomes SUB.
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.legal     = 1'b1;
        case (f3)
          3'b000:  c.alu_ctrl = ALU_ADD;
          3'b001:  c.alu_ctrl = ALU_SLL;
          default: c = '0;
        endcase
      end
      7'b0000011: begin
        if (f3 == 3'b011) begin
          c.legal      = 1'b1;
          c.is_load    = 1'b1;
          c.alu_src    = 1'b1;
          c.mem_to_reg = 1'b1;
          c.reg_write  = 1'b1;
          c.alu_ctrl   = ALU_ADD;
        end
      end
      7'b0100011: begin
        if (f3 == 3'b011) begin
          c.legal    = 1'b1;
          c.is_store = 1'b1;
          c.alu_src  = 1'b1;
          c.alu_ctrl = ALU_ADD;
        end
      end
      7'b1100011: begin
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101) begin
          c.legal     = 1'b1;
          c.is_branch = 1'b1;
          c.alu_ctrl  = ALU_CMP;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;
  logic              tmo_hit;
  logic [6:0]        ir_op;
  logic [2:0]        ir_f3;
  logic              ir_b30;
  ctl_t              dec;
  ctl_t              ctl_q;

  logic unused_bits;
  assign unused_bits = ^{instruction[ILEN-1:31], instruction[29:15],
                         instruction[11:7], ctl_q.legal};

  assign dec   = decode(ir_op, ir_f3, ir_b30);
  assign state = state_q;

  // State register, wait counter, captured instruction fields, decoded controls and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      ir_op    <= '0;
      ir_f3    <= '0;
      ir_b30   <= 1'b0;
      ctl_q    <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state_q == S_FETCH && imem_ready) begin
        ir_op  <= instruction[6:0];
        ir_f3  <= instruction[14:12];
        ir_b30 <= instruction[30];
      end
      if (state_q == S_DECODE) begin
        ctl_q <= dec;
        if (!dec.legal) begin
          illegal <= 1'b1;
        end
      end
      if (tmo_hit) begin
        timeout <= 1'b1;
      end
    end
  end

  // Next-state selection and per-state strobes; a ready in the counter==MEM_TIMEOUT cycle still succeeds.
  always_comb begin
    state_d    = state_q;
    wait_inc   = 1'b0;
    tmo_hit    = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_ctrl   = 4'b0000;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          tmo_hit = 1'b1;
          state_d = S_TRAP;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = dec.legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_ctrl = ctl_q.alu_ctrl;
        alu_src  = ctl_q.alu_src;
        if (ctl_q.is_branch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken;
          state_d  = S_FETCH;
        end else if (ctl_q.is_load || ctl_q.is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read   = ctl_q.is_load;
        mem_write  = ctl_q.is_store;
        mem_to_reg = ctl_q.mem_to_reg;
        if (dmem_ready) begin
          if (ctl_q.is_store) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          tmo_hit = 1'b1;
          state_d = S_TRAP;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        reg_write  = ctl_q.reg_write;
        mem_to_reg = ctl_q.mem_to_reg;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // While reset is held every output stays quiet regardless of the inputs.
    if (!rst_n) begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      alu_ctrl   = 4'b0000;
      tmo_hit    = 1'b0;
      wait_inc   = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  // Free-running performance counters: active cycles and retired instructions (one per pc_write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_TRAP) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (pc_write) begin
        instret_cnt <= instret_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level model expands each
// instruction into its expected per-cycle outputs, a driver applies inputs and
// queues expectations, and an independent monitor pops and compares each cycle.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam int TMO      = 16;
  localparam int TB_CNT_W = 4;
  localparam int NEVER    = 1000;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, ir_write, pc_write, pc_src, mem_read, mem_write;
  logic        mem_to_reg, alu_src, reg_write, illegal, timeout;
  logic [3:0]  alu_ctrl;
  logic [2:0]  state;
`ifdef PERF_CNT_EN
  logic [TB_CNT_W-1:0] cycle_cnt, instret_cnt;
`endif

  multicycle_control_unit #(.ILEN(32), .MEM_TIMEOUT(TMO), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .reg_write(reg_write), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .timeout(timeout), .state(state)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [3:0] alu;
    logic       ill;
    logic       tmo;
  } exp_t;

  typedef struct {
    exp_t                e;
    logic [TB_CNT_W-1:0] cyc;
    logic [TB_CNT_W-1:0] ret;
    int                  tag;
  } sb_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        ir;
    logic        dr;
    logic        bt;
    exp_t        e;
  } cyc_t;

  sb_t                 sb[$];
  int                  checks = 0;
  int                  errors = 0;
  int                  tag = 0;
  logic [TB_CNT_W-1:0] m_cyc = '0;
  logic [TB_CNT_W-1:0] m_ret = '0;

  // Instruction class from the legal {funct3, opcode} table.
  function automatic int classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    if (op == 7'b0110011 && f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7}) return K_R;
    if (op == 7'b0010011 && f3 inside {3'd0, 3'd1}) return K_I;
    if (op == 7'b0000011 && f3 == 3'd3) return K_LD;
    if (op == 7'b0100011 && f3 == 3'd3) return K_ST;
    if (op == 7'b1100011 && f3 inside {3'd0, 3'd1, 3'd4, 3'd5}) return K_BR;
    return K_ILL;
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] w);
    int k;
    k = classify(w);
    if (k == K_BR) return 4'b1000;
    if (k == K_R || k == K_I) begin
      case (w[14:12])
        3'd0:    return (k == K_R && w[30]) ? 4'b0001 : 4'b0000;
        3'd1:    return 4'b0010;
        3'd4:    return 4'b0011;
        3'd5:    return w[30] ? 4'b0101 : 4'b0100;
        3'd6:    return 4'b0110;
        default: return 4'b0111;
      endcase
    end
    return 4'b0000;
  endfunction

  function automatic logic [31:0] make_word(input int kind);
    logic [31:0] w;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [6:0]  ops [5];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    w  = $urandom;
    f3 = 3'd0;
    op = 7'd0;
    case (kind)
      K_R: begin
        op = 7'b0110011;
        do f3 = 3'($urandom_range(0, 7)); while (f3 == 3'd2 || f3 == 3'd3);
      end
      K_I: begin
        op = 7'b0010011;
        f3 = 3'($urandom_range(0, 1));
      end
      K_LD: begin op = 7'b0000011; f3 = 3'd3; end
      K_ST: begin op = 7'b0100011; f3 = 3'd3; end
      K_BR: begin
        op = 7'b1100011;
        f3 = 3'($urandom_range(0, 1)) | ($urandom_range(0, 1) == 1 ? 3'd4 : 3'd0);
      end
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          do w = $urandom; while (classify(w) != K_ILL);
          return w;
        end
        op = ops[$urandom_range(0, 4)];
        do f3 = 3'($urandom_range(0, 7));
        while (classify({w[31:15], f3, w[11:7], op}) != K_ILL);
      end
    endcase
    return {w[31:15], f3, w[11:7], op};
  endfunction

  function automatic cyc_t mk(input logic [2:0] st);
    cyc_t c;
    c.rst   = 1'b1;
    c.instr = $urandom;
    c.ir    = 1'($urandom_range(0, 1));
    c.dr    = 1'($urandom_range(0, 1));
    c.bt    = 1'($urandom_range(0, 1));
    c.e     = '0;
    c.e.st  = st;
    return c;
  endfunction

  // Apply one cycle of inputs and queue what the monitor must see in that cycle.
  task automatic drive(input cyc_t c);
    sb_t s;
    @(posedge clk);
    #1;
    rst_n        = c.rst;
    instruction  = c.instr;
    imem_ready   = c.ir;
    dmem_ready   = c.dr;
    branch_taken = c.bt;
    if (!c.rst) begin
      m_cyc = '0;
      m_ret = '0;
    end
    s.e   = c.e;
    s.cyc = m_cyc;
    s.ret = m_ret;
    s.tag = tag;
    if (c.rst) begin
      if (c.e.st != 3'd7) m_cyc = m_cyc + 1'b1;
      if (c.e.pc_write)   m_ret = m_ret + 1'b1;
    end
    sb.push_back(s);
  endtask

  task automatic do_reset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = mk(3'd0);
      c.rst = 1'b0;
      drive(c);
    end
  endtask

  // Expand one instruction into its cycle sequence: di/dd are the number of
  // not-ready cycles before imem/dmem ready (NEVER = no ready), btf forces
  // branch_taken (-1 = random), abort_at truncates with a reset.
  task automatic run_instr(input logic [31:0] w, input int di, input int dd,
                           input int btf, input int abort_at);
    cyc_t tr[$];
    cyc_t c;
    int   kind;
    int   n;
    logic trap;
    logic ill_t;
    kind  = classify(w);
    trap  = 1'b0;
    ill_t = 1'b0;
    tag++;
    for (int k = 0; k <= TMO; k++) begin
      c = mk(3'd0);
      c.e.imem_req = 1'b1;
      if (k == di) begin
        c.ir = 1'b1;
        c.instr = w;
        c.e.ir_write = 1'b1;
        tr.push_back(c);
        break;
      end
      c.ir = 1'b0;
      tr.push_back(c);
      if (k == TMO) trap = 1'b1;
    end
    if (!trap) begin
      tr.push_back(mk(3'd1));
      if (kind == K_ILL) begin
        trap  = 1'b1;
        ill_t = 1'b1;
      end
    end
    if (!trap) begin
      c = mk(3'd2);
      if (btf >= 0) c.bt = btf[0];
      c.e.alu     = alu_of(w);
      c.e.alu_src = (kind == K_I || kind == K_LD || kind == K_ST);
      if (kind == K_BR) begin
        c.e.pc_write = 1'b1;
        c.e.pc_src   = c.bt;
      end
      tr.push_back(c);
    end
    if (!trap && (kind == K_LD || kind == K_ST)) begin
      for (int k = 0; k <= TMO; k++) begin
        c = mk(3'd3);
        c.e.mem_read   = (kind == K_LD);
        c.e.mem_write  = (kind == K_ST);
        c.e.mem_to_reg = (kind == K_LD);
        if (k == dd) begin
          c.dr = 1'b1;
          c.e.pc_write = (kind == K_ST);
          tr.push_back(c);
          break;
        end
        c.dr = 1'b0;
        tr.push_back(c);
        if (k == TMO) trap = 1'b1;
      end
    end
    if (!trap && (kind == K_R || kind == K_I || kind == K_LD)) begin
      c = mk(3'd4);
      c.e.reg_write  = 1'b1;
      c.e.pc_write   = 1'b1;
      c.e.mem_to_reg = (kind == K_LD);
      tr.push_back(c);
    end
    if (trap) begin
      for (int k = 0; k < 20; k++) begin
        c = mk(3'd7);
        c.e.ill = ill_t;
        c.e.tmo = !ill_t;
        tr.push_back(c);
      end
    end
    n = (abort_at < tr.size()) ? abort_at : tr.size();
    for (int i = 0; i < n; i++) drive(tr[i]);
    if (trap || n < tr.size()) do_reset(1 + $urandom_range(0, 2));
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 99);
    if (r < 85) return $urandom_range(0, 3);
    if (r < 92) return TMO;
    if (r < 96) return TMO - 1;
    return NEVER;
  endfunction

  // Monitor: every cycle with a queued expectation, compare the DUT outputs.
  initial begin
    sb_t  s;
    exp_t act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        s = sb.pop_front();
        act.st         = state;
        act.imem_req   = imem_req;
        act.ir_write   = ir_write;
        act.pc_write   = pc_write;
        act.pc_src     = pc_src;
        act.mem_read   = mem_read;
        act.mem_write  = mem_write;
        act.mem_to_reg = mem_to_reg;
        act.alu_src    = alu_src;
        act.reg_write  = reg_write;
        act.alu        = alu_ctrl;
        act.ill        = illegal;
        act.tmo        = timeout;
        checks++;
        if (act !== s.e) begin
          errors++;
          $display("FAIL outputs instr#%0d t=%0t: got st=%0d bits=%b, expected st=%0d bits=%b",
                   s.tag, $time, act.st, act, s.e.st, s.e);
        end
`ifdef PERF_CNT_EN
        checks++;
        if (cycle_cnt !== s.cyc || instret_cnt !== s.ret) begin
          errors++;
          $display("FAIL perf_cnt instr#%0d t=%0t: got cycle=%0d instret=%0d, expected cycle=%0d instret=%0d",
                   s.tag, $time, cycle_cnt, instret_cnt, s.cyc, s.ret);
        end
`endif
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized instruction stream.
  initial begin
    int kind;
    int abort_at;
    do_reset(3);
    run_instr(32'h002081B3, 0, 0, -1, NEVER);      // ADD, zero wait
    run_instr(32'h0000B183, 0, 3, -1, NEVER);      // LD, dmem 3 cycles late
    run_instr(32'h00209463, 0, 0, 1, NEVER);       // BNE taken
    run_instr(32'h0000007F, 0, 0, -1, NEVER);      // illegal opcode -> TRAP
    run_instr(32'h002081B3, NEVER, 0, -1, NEVER);  // imem never ready -> timeout
    run_instr(32'h002081B3, TMO, 0, -1, NEVER);    // imem ready at the limit
    run_instr(32'h0000B183, 0, NEVER, -1, NEVER);  // dmem never ready -> timeout
    run_instr(32'h0020B023, 1, TMO, -1, NEVER);    // store, dmem ready at the limit
    do_reset(2);
    repeat (11) run_instr(32'h002081B3, 0, 0, -1, NEVER);
    run_instr(32'h0020B023, 0, 0, -1, 2);          // store abandoned by reset
    for (int i = 0; i < 200; i++) begin
      kind     = $urandom_range(0, 5);
      abort_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : NEVER;
      run_instr(make_word(kind), pick_delay(), pick_delay(), -1, abort_at);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
